// File: rtl/bcd_event_counter.sv
// Eight-digit BCD up/down event counter driven by two bouncing push-buttons.
// Each button is synchronized, debounced and turned into a single rising-edge step pulse.

module bcd_event_counter_debounce #(
    parameter int DB_COUNT = 1000000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic btn,
    output logic step
);
    localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

    logic          sync1;
    logic          s;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            cnt   <= '0;
            step  <= 1'b0;
        end else begin
            sync1 <= btn;
            s     <= sync1;
            db_q  <= db;
            // Only a debounced press (0->1) produces a step; releases are silent.
            step  <= db & ~db_q;
            if (s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module bcd_event_counter #(
    parameter int DB_COUNT = 1000000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       btn_inc,
    input  logic       btn_clr,
    input  logic       up,
    output logic [3:0] d7,
    output logic [3:0] d6,
    output logic [3:0] d5,
    output logic [3:0] d4,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       ovf
);
    logic            inc_step;
    logic            clr_step;
    logic [7:0][3:0] dig;
    logic [7:0][3:0] nxt;
    logic            carry;

    bcd_event_counter_debounce #(.DB_COUNT(DB_COUNT)) u_db_inc (
        .clk_in (clk_in),
        .reset  (reset),
        .btn    (btn_inc),
        .step   (inc_step)
    );

    bcd_event_counter_debounce #(.DB_COUNT(DB_COUNT)) u_db_clr (
        .clk_in (clk_in),
        .reset  (reset),
        .btn    (btn_clr),
        .step   (clr_step)
    );

    // Ripple carry/borrow from d0 upward; carry surviving past d7 means wrap-around.
    always_comb begin
        nxt   = dig;
        carry = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (up) begin
                    if (dig[i] == 4'd9) begin
                        nxt[i] = 4'd0;
                    end else begin
                        nxt[i] = dig[i] + 4'd1;
                        carry  = 1'b0;
                    end
                end else begin
                    if (dig[i] == 4'd0) begin
                        nxt[i] = 4'd9;
                    end else begin
                        nxt[i] = dig[i] - 4'd1;
                        carry  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            dig <= '0;
            ovf <= 1'b0;
        end else if (clr_step) begin
            dig <= '0;
            ovf <= 1'b0;
        end else if (inc_step) begin
            dig <= nxt;
            ovf <= carry;
        end else begin
            ovf <= 1'b0;
        end
    end

    assign {d7, d6, d5, d4, d3, d2, d1, d0} = dig;
endmodule

// File: tb/tb_bcd_event_counter.sv
// Directed test of bcd_event_counter with DB_COUNT=4: latency, bounce rejection,
// BCD carry/borrow, wrap-around ovf, clear priority and asynchronous reset.

module tb_bcd_event_counter;
    logic       clk_in;
    logic       reset;
    logic       btn_inc;
    logic       btn_clr;
    logic       up;
    logic [3:0] d7, d6, d5, d4, d3, d2, d1, d0;
    logic       ovf;

    int vectors   = 0;
    int miscompares = 0;
    int ovf_seen;
    int ovf_sum;

    bcd_event_counter #(.DB_COUNT(4)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .btn_inc (btn_inc),
        .btn_clr (btn_clr),
        .up      (up),
        .d7      (d7),
        .d6      (d6),
        .d5      (d5),
        .d4      (d4),
        .d3      (d3),
        .d2      (d2),
        .d1      (d1),
        .d0      (d0),
        .ovf     (ovf)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] digits();
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One debounced press then a debounced release; counts cycles with ovf high.
    task automatic press(input logic do_inc, input logic do_clr, output int seen);
        seen = 0;
        @(negedge clk_in);
        btn_inc = do_inc;
        btn_clr = do_clr;
        repeat (10) begin
            @(negedge clk_in);
            if (ovf) seen++;
        end
        btn_inc = 1'b0;
        btn_clr = 1'b0;
        repeat (10) begin
            @(negedge clk_in);
            if (ovf) seen++;
        end
    endtask

    // Called on a negedge; the next posedge is the first edge sampling btn_inc high.
    task automatic check_latency(input string tag);
        btn_inc = 1'b1;
        repeat (7) @(negedge clk_in);
        check({tag, "_edge7"}, digits(), 32'h00000000);
        @(negedge clk_in);
        check({tag, "_edge8"}, digits(), 32'h00000001);
        check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
        repeat (10) @(negedge clk_in);
        check({tag, "_held"}, digits(), 32'h00000001);
        btn_inc = 1'b0;
        repeat (10) @(negedge clk_in);
    endtask

    initial begin
        reset   = 1'b1;
        btn_inc = 1'b0;
        btn_clr = 1'b0;
        up      = 1'b1;
        repeat (3) @(negedge clk_in);
        check("reset_digits", digits(), 32'h00000000);
        check("reset_ovf", {31'd0, ovf}, 32'd0);

        // Exact press latency after reset release
        reset = 1'b0;
        check_latency("latency");

        // Bounce shorter than the debounce window
        @(negedge clk_in);
        ovf_seen = 0;
        for (int i = 0; i < 20; i++) begin
            btn_inc = ~btn_inc;
            repeat (2) begin
                @(negedge clk_in);
                if (ovf) ovf_seen++;
            end
        end
        btn_inc = 1'b0;
        repeat (10) @(negedge clk_in);
        check("bounce_digits", digits(), 32'h00000001);
        check("bounce_ovf", ovf_seen, 32'd0);

        press(1'b0, 1'b1, ovf_seen);
        check("clear", digits(), 32'h00000000);

        // Carry across digits
        ovf_sum = 0;
        for (int i = 0; i < 99; i++) begin
            press(1'b1, 1'b0, ovf_seen);
            ovf_sum += ovf_seen;
        end
        check("count_99", digits(), 32'h00000099);
        check("count_99_ovf", ovf_sum, 32'd0);
        press(1'b1, 1'b0, ovf_seen);
        check("count_100", digits(), 32'h00000100);

        // Borrow and down wrap
        press(1'b0, 1'b1, ovf_seen);
        check("clear2", digits(), 32'h00000000);
        up = 1'b0;
        press(1'b1, 1'b0, ovf_seen);
        check("down_wrap", digits(), 32'h99999999);
        check("down_wrap_ovf", ovf_seen, 32'd1);
        press(1'b1, 1'b0, ovf_seen);
        check("down_98", digits(), 32'h99999998);
        check("down_98_ovf", ovf_seen, 32'd0);

        // Up wrap from 99999999
        up = 1'b1;
        press(1'b1, 1'b0, ovf_seen);
        check("up_99999999", digits(), 32'h99999999);
        press(1'b1, 1'b0, ovf_seen);
        check("up_wrap", digits(), 32'h00000000);
        check("up_wrap_ovf", ovf_seen, 32'd1);

        // Direction changed mid-debounce applies at the step
        up = 1'b0;
        @(negedge clk_in);
        btn_inc = 1'b1;
        repeat (3) @(negedge clk_in);
        up = 1'b1;
        repeat (7) @(negedge clk_in);
        btn_inc = 1'b0;
        repeat (10) @(negedge clk_in);
        check("dir_change", digits(), 32'h00000001);

        // Clear wins over a simultaneous increment
        for (int i = 0; i < 41; i++) press(1'b1, 1'b0, ovf_seen);
        check("count_42", digits(), 32'h00000042);
        press(1'b1, 1'b1, ovf_seen);
        check("clr_wins", digits(), 32'h00000000);
        check("clr_wins_ovf", ovf_seen, 32'd0);

        // Asynchronous reset takes effect between edges
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, ovf_seen);
        check("count_3", digits(), 32'h00000003);
        @(negedge clk_in);
        #2 reset = 1'b1;
        #1 check("async_reset", digits(), 32'h00000000);
        check("async_reset_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk_in);
        reset = 1'b0;

        // Reset mid-debounce restarts the full window with the button still held
        press(1'b1, 1'b0, ovf_seen);
        check("pre_abort", digits(), 32'h00000001);
        @(negedge clk_in);
        btn_inc = 1'b1;
        repeat (4) @(negedge clk_in);
        reset = 1'b1;
        repeat (2) @(negedge clk_in);
        check("abort_reset", digits(), 32'h00000000);
        reset = 1'b0;
        check_latency("abort_latency");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_event_counter.md
BCD_EVENT_COUNTER -- requirements
Module: bcd_event_counter

Interface
REQ-001 Parameter DB_COUNT, default 1000000, is the number of stable-input cycles required to accept a button level (10 ms at 100 MHz).
REQ-002 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 btn_inc  input  1  raw push-button (asynchronous to clk_in, bouncing); a press requests one count step.
REQ-005 btn_clr  input  1  raw push-button (asynchronous, bouncing); a press clears the count.
REQ-006 up  input  1  direction switch: 1 = increment, 0 = decrement; sampled on the step cycle.
REQ-007 d7..d0  output  4 each  BCD digits of the count (d7 most significant); drive the display controller digit inputs directly.
REQ-008 ovf  output  1  one-cycle pulse on wrap-around in either direction.

Function
REQ-009 Each button input SHALL pass through its own two-flop synchronizer; only the second flop's output (s) is used.
REQ-010 Each button SHALL have a debouncer holding a debounced level db and a stability counter cnt sized to reach DB_COUNT-1.
REQ-011 Debouncer rules:
- s == db: cnt <= 0.
- s != db and cnt < DB_COUNT-1: cnt <= cnt+1.
- s != db and cnt == DB_COUNT-1: db <= s; cnt <= 0.
REQ-012 A one-cycle step pulse SHALL be registered on the cycle after db transitions 0->1; no pulse on a 1->0 transition.
REQ-013 The digit registers SHALL update on the clock edge after the step pulse is high; total latency from the first edge sampling a stable high btn_inc to the changed d outputs is DB_COUNT+4 edges.
REQ-014 Any bounce shorter than DB_COUNT cycles SHALL leave db unchanged and produce no pulse.
REQ-015 A button held indefinitely SHALL yield exactly one pulse; the next pulse requires a debounced release followed by a debounced press.
REQ-016 On an inc pulse with up=1, the count SHALL advance by one in BCD:
- each digit wraps 9->0 with carry into the next digit;
- no digit ever holds a value greater than 9.
REQ-017 On an inc pulse with up=0, the count SHALL decrement by one in BCD: each digit wraps 0->9 with borrow.
REQ-018 Wrap-around:
- up=1 at 99999999 -> 00000000 with ovf=1 for that one update cycle;
- up=0 at 00000000 -> 99999999 with ovf=1.
REQ-019 A clr pulse SHALL set all digits to 0 with ovf=0.
REQ-020 If clr and inc pulses occur in the same cycle, clr SHALL win and the inc step is discarded.
REQ-021 The count SHALL hold its value in every cycle without a pulse; ovf=0 in every cycle without a wrap.
REQ-022 Changing up while a button is mid-debounce SHALL take effect only at the step cycle; no glitch step occurs.

Reset
REQ-023 While reset is high:
- sync flops, db, cnt and step pulses = 0;
- d7..d0 = 4'h0; ovf = 0.
REQ-024 Reset asserted mid-debounce SHALL abort the debounce; after release, a button already held high requires a full DB_COUNT stable window before it is accepted (db starts at 0).
REQ-025 Counting SHALL resume on the first pulse after reset deasserts; there are no other init cycles.

Verification (DB_COUNT=4 in simulation)
REQ-026 Reset released, btn_inc held high -> digits read 00000001 exactly 8 edges after the first edge sampling it high; ovf stays 0; holding longer gives no further change.
REQ-027 btn_inc toggled high/low every 2 cycles for 40 cycles, then low -> digits unchanged, no pulse.
REQ-028 Load 00000099 via 99 presses with up=1, then one more press -> 00000100; preload 99999999, press -> 00000000 with ovf=1 for exactly one cycle.
REQ-029 Count 00000000 with up=0, one press -> 99999999 and ovf=1; one further press -> 99999998.
REQ-030 btn_inc and btn_clr pressed on the same cycle at count 00000042 -> 00000000 with no increment; reset asserted asynchronously mid-count -> all d = 0 immediately, before the next clock edge.
